// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encodings and constants for the PC sequencer
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RST  = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10
    } state_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Control-transfer addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - SPARC PC/nPC sequencer with delayed branches, annul, stall and trap entry
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        br_annul,
    input  logic        trap_req,
    input  logic [31:0] trap_vector,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_y,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        fetch_valid,
    output logic        annul_slot,
    output logic        trap_ack
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic        annul_q, annul_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        annul_d = annul_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (trap_req) begin
                    pc_d    = word_align(trap_vector);
                    annul_d = 1'b0;
                    state_d = ST_TRAP;
                end else if (!stall) begin
                    pc_d    = npc_q;
                    npc_d   = br_taken ? word_align(br_target) : add_y;
                    annul_d = br_annul & ~br_taken;
                end
            end
            ST_TRAP: begin
                // The adder sees pc (the vector) here, so add_y is vector+4.
                npc_d   = add_y;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_RST;
            pc_q    <= RESET_VECTOR;
            npc_q   <= RESET_VECTOR + INSTR_BYTES;
            annul_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            annul_q <= annul_d;
        end
    end

    assign add_a       = (state_q == ST_TRAP) ? pc_q : npc_q;
    assign add_b       = INSTR_BYTES;
    assign pc          = pc_q;
    assign npc         = npc_q;
    assign annul_slot  = annul_q;
    assign fetch_valid = (state_q == ST_RUN);
    assign trap_ack    = (state_q == ST_TRAP);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer with a behavioural model
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        br_annul;
    logic        trap_req;
    logic [31:0] trap_vector;
    logic [31:0] add_a, add_b, add_y;
    logic [31:0] pc, npc;
    logic        fetch_valid, annul_slot, trap_ack;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Stand-in for the external 32-bit Adder in the fetch-stage parent.
    assign add_y = add_a + add_b;

    pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .br_annul    (br_annul),
        .trap_req    (trap_req),
        .trap_vector (trap_vector),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_y       (add_y),
        .pc          (pc),
        .npc         (npc),
        .fetch_valid (fetch_valid),
        .annul_slot  (annul_slot),
        .trap_ack    (trap_ack)
    );

    typedef enum {M_RESET, M_RUNNING, M_TRAPPING} mode_t;
    mode_t       m_mode;
    logic [31:0] m_pc, m_npc;
    logic        m_annul;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural effect of one clock edge, from the sequencing rules.
    task automatic model_edge();
        if (!reset_n) begin
            m_mode  = M_RESET;
            m_pc    = 32'h0;
            m_npc   = 32'h4;
            m_annul = 1'b0;
        end else if (m_mode == M_RESET) begin
            m_mode = M_RUNNING;
        end else if (m_mode == M_TRAPPING) begin
            m_npc  = m_pc + 32'd4;
            m_mode = M_RUNNING;
        end else if (trap_req) begin
            m_pc    = trap_vector & 32'hFFFF_FFFC;
            m_annul = 1'b0;
            m_mode  = M_TRAPPING;
        end else if (!stall) begin
            m_pc    = m_npc;
            m_npc   = br_taken ? (br_target & 32'hFFFF_FFFC) : m_npc + 32'd4;
            m_annul = br_annul && !br_taken;
        end
    endtask

    task automatic check_all();
        cmp("pc", pc, m_pc);
        cmp("npc", npc, m_npc);
        cmp("annul_slot", {31'd0, annul_slot}, {31'd0, m_annul});
        cmp("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_mode == M_RUNNING});
        cmp("trap_ack", {31'd0, trap_ack}, {31'd0, m_mode == M_TRAPPING});
        cmp("add_a", add_a, (m_mode == M_TRAPPING) ? m_pc : m_npc);
        cmp("add_b", add_b, 32'd4);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        stall = 0; br_taken = 0; br_target = 0; br_annul = 0;
        trap_req = 0; trap_vector = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        step();
        step();
        reset_n = 1;
    endtask

    initial begin
        idle_inputs();
        reset_n = 0;
        do_reset();
        cmp("lit_rst_pc", pc, 32'h0);
        cmp("lit_rst_add_a", add_a, 32'h4);
        cmp("lit_rst_fv", {31'd0, fetch_valid}, 32'd0);

        step();
        cmp("lit_first_fetch_pc", pc, 32'h0);
        cmp("lit_first_fetch_fv", {31'd0, fetch_valid}, 32'd1);
        step(); step(); step();
        cmp("lit_seq_pc", pc, 32'hC);
        cmp("lit_seq_npc", npc, 32'h10);

        // Taken branch at pc=8
        do_reset(); step(); step(); step();
        cmp("lit_br_at", pc, 32'h8);
        br_taken = 1; br_target = 32'h100;
        step();
        br_taken = 0; br_target = 0;
        cmp("lit_delay_slot", pc, 32'hC);
        step();
        cmp("lit_target", pc, 32'h100);
        step();
        cmp("lit_target_plus4", pc, 32'h104);

        // Untaken annulling branch at pc=8
        do_reset(); step(); step(); step();
        br_annul = 1;
        step();
        br_annul = 0;
        cmp("lit_annul_set", {31'd0, annul_slot}, 32'd1);
        step();
        cmp("lit_annul_clr_pc", pc, 32'h10);

        // Stall with a taken branch presented
        stall = 1; br_taken = 1; br_target = 32'h500;
        repeat (3) step();
        cmp("lit_stall_pc", pc, 32'h10);
        cmp("lit_stall_npc", npc, 32'h14);
        idle_inputs();
        repeat (4) step();
        cmp("lit_resume_pc", pc, 32'h20);

        // Trap overriding stall, unaligned vector
        trap_req = 1; stall = 1; trap_vector = 32'h803; br_taken = 1; br_target = 32'h900;
        step();
        idle_inputs();
        cmp("lit_trap_pc", pc, 32'h800);
        cmp("lit_trap_ack", {31'd0, trap_ack}, 32'd1);
        trap_req = 1;
        step();
        trap_req = 0;
        cmp("lit_trap_exit_npc", npc, 32'h804);
        cmp("lit_trap_exit_fv", {31'd0, fetch_valid}, 32'd1);

        // Wraparound of nPC
        br_taken = 1; br_target = 32'hFFFF_FFFA;
        step();
        idle_inputs();
        step(); step();
        cmp("lit_wrap_pc", pc, 32'hFFFF_FFFC);
        cmp("lit_wrap_npc", npc, 32'h0);

        // Reset during TRAP
        trap_req = 1; trap_vector = 32'h40;
        step();
        trap_req = 0;
        reset_n = 0;
        step();
        cmp("lit_rst_in_trap_pc", pc, 32'h0);
        cmp("lit_rst_in_trap_ack", {31'd0, trap_ack}, 32'd0);
        reset_n = 1;
        repeat (3) step();

        // Stall then trap mixed sequence
        stall = 1; step(); stall = 0; step();
        trap_req = 1; trap_vector = 32'h1234_5677; step();
        trap_req = 0; step(); step();
        cmp("lit_after_trap_pc", pc, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
